// File: rtl/timer_counter_pkg.sv
// Shared definitions for the timer/counter: FSM state encoding, register
// offsets, CTRL bit positions and MODE encodings.
package tc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tc_state_e;

  // Byte offsets within the device window; only bits [3:2] are decoded.
  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_PRESET = 4'h4;
  localparam logic [3:0] OFF_COUNT  = 4'h8;
  localparam logic [3:0] OFF_RSVD   = 4'hC;

  // CTRL register layout.
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;

  // MODE encodings; 2 and 3 decode as one-shot.
  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_AUTO    = 2'd1;

  // CTRL holds only four bits; the upper bits of the read word are zero.
  function automatic logic [31:0] ctrl_readback(input logic [3:0] ctrl);
    return {28'd0, ctrl};
  endfunction

endpackage

// File: rtl/timer_counter_if.sv
// Register bus between the bridge and the timer/counter.
// Handshake: there is no valid/ready pair on this bus. WE is a one-cycle
// write strobe already qualified by the bridge; a write is always accepted
// on the rising edge where WE=1. Reads have no strobe: Dout follows Addr
// combinationally in the same cycle. IRQ is a registered level.
interface timer_counter_if;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  modport master (
    output Addr,
    output WE,
    output Din,
    input  Dout,
    input  IRQ
  );

  modport slave (
    input  Addr,
    input  WE,
    input  Din,
    output Dout,
    output IRQ
  );
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot and auto-reload modes.
// CTRL/PRESET/COUNT registers, a four-state FSM and a registered IRQ.
// Optional feature macro: TC_AUTORELOAD_EN enables MODE=1 auto-reload;
// when undefined, MODE is stored but always decoded as one-shot.
module timer_counter
  import tc_pkg::*;
#(
  parameter logic [31:0] PRESET_RST = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output tc_state_e   dbg_state_o
);

  tc_state_e   state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;
  logic        irq_q, irq_d;

  logic [1:0]  reg_sel;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        ctrl_en;
  logic        auto_mode;
  logic        irq_set;
  logic        unused_addr;

  assign reg_sel     = Addr[3:2];
  assign wr_ctrl     = WE && (reg_sel == OFF_CTRL[3:2]);
  assign wr_preset   = WE && (reg_sel == OFF_PRESET[3:2]);
  assign ctrl_en     = ctrl_q[CTRL_EN_BIT];
  assign unused_addr = ^{Addr[31:4], Addr[1:0]};

`ifdef TC_AUTORELOAD_EN
  assign auto_mode = (ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_AUTO);
`else
  assign auto_mode = 1'b0;
`endif

  // Read mux: combinational from the decoded offset; reserved slot reads 0.
  always_comb begin
    Dout = 32'd0;
    case (reg_sel)
      OFF_CTRL[3:2]:   Dout = ctrl_readback(ctrl_q);
      OFF_PRESET[3:2]: Dout = preset_q;
      OFF_COUNT[3:2]:  Dout = count_q;
      default:         Dout = 32'd0;
    endcase
  end

  // Next-state logic for the FSM, counter, flag and registers.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
    irq_set    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ctrl_en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_en) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // PRESET=0 lands here too, so it behaves like PRESET=1.
          count_d    = 32'd0;
          irq_flag_d = 1'b1;
          irq_set    = 1'b1;
          state_d    = ST_INT;
        end
      end
      ST_INT: begin
        state_d = ST_IDLE;
        if (auto_mode) irq_flag_d = 1'b0;
        else           ctrl_d[CTRL_EN_BIT] = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    // Bus writes override any FSM update to EN in the same cycle. A CTRL
    // write acknowledges the flag unless the flag is being raised right now,
    // so a terminal count is never lost.
    if (wr_ctrl) begin
      ctrl_d = Din[3:0];
      if (!irq_set) irq_flag_d = 1'b0;
    end
    if (wr_preset) preset_d = Din;

    irq_d = irq_flag_d & ctrl_d[CTRL_IM_BIT];
  end

  // State and register update with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= 4'd0;
      preset_q   <= PRESET_RST;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
      irq_q      <= irq_d;
    end
  end

  assign IRQ         = irq_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: register map, one-shot and
// auto-reload timing, PRESET corner values, masked IRQ, stop mid-count,
// bus-over-FSM priority on EN and asynchronous reset mid-count.
module tb_timer_counter;
  import tc_pkg::*;

  localparam logic [31:0] PRESET_RST_VAL = 32'hA5A5_0003;

  logic      clk;
  logic      reset;
  tc_state_e dbg_state;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [31:0] exp_q[$];

  timer_counter_if bus ();

  timer_counter #(.PRESET_RST(PRESET_RST_VAL)) dut (
    .clk         (clk),
    .reset       (reset),
    .Addr        (bus.Addr),
    .WE          (bus.WE),
    .Din         (bus.Din),
    .Dout        (bus.Dout),
    .IRQ         (bus.IRQ),
    .dbg_state_o (dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Compare one observed value against one expected value.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expectation and compare it with an observed value.
  task automatic sb_pop_check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL %s: scoreboard empty, got 0x%08h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, obs, e);
    end
  endtask

  // Driver: single-cycle write; returns 1ns after the accepting edge.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.Addr = addr;
    bus.Din  = data;
    bus.WE   = 1'b1;
    @(posedge clk);
    #1;
    bus.WE   = 1'b0;
  endtask

  // Advance k rising edges and settle 1ns past the last one.
  task automatic wait_edges(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Combinational read of one offset, checked against the scoreboard.
  task automatic expect_rd(input string tag, input logic [31:0] addr, input logic [31:0] val);
    exp_q.push_back(val);
    bus.Addr = addr;
    bus.WE   = 1'b0;
    #1;
    sb_pop_check(tag, bus.Dout);
  endtask

  task automatic expect_irq(input string tag, input logic val);
    exp_q.push_back({31'd0, val});
    sb_pop_check(tag, {31'd0, bus.IRQ});
  endtask

  task automatic expect_state(input string tag, input tc_state_e st);
    exp_q.push_back({30'd0, st});
    sb_pop_check(tag, {30'd0, dbg_state});
  endtask

  logic auto_en;
  logic e_irq;

  initial begin
`ifdef TC_AUTORELOAD_EN
    auto_en = 1'b1;
`else
    auto_en = 1'b0;
`endif
    bus.Addr = 32'd0;
    bus.Din  = 32'd0;
    bus.WE   = 1'b0;
    reset    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    wait_edges(1);

    // Reset state and register map.
    expect_rd("rst_ctrl", 32'h0, 32'd0);
    expect_rd("rst_preset", 32'h4, PRESET_RST_VAL);
    expect_rd("rst_count", 32'h8, 32'd0);
    expect_rd("rst_rsvd", 32'hC, 32'd0);
    expect_irq("rst_irq", 1'b0);
    expect_state("rst_state", ST_IDLE);

    // One-shot, PRESET=5, IM=1.
    bus_write(32'h4, 32'd5);
    bus_write(32'h0, 32'h9);            // edge W
    wait_edges(1);
    expect_state("os_load", ST_LOAD);
    wait_edges(1);
    expect_rd("os_count_w2", 32'h8, 32'd5);
    expect_state("os_cnt", ST_CNT);
    for (int k = 3; k <= 7; k++) begin
      wait_edges(1);
      expect_irq($sformatf("os_irq_w%0d", k), (k == 7));
    end
    expect_state("os_int", ST_INT);
    wait_edges(1);
    expect_irq("os_irq_hold1", 1'b1);
    expect_state("os_idle", ST_IDLE);
    expect_rd("os_ctrl_en_clr", 32'h0, 32'h8);
    expect_rd("os_count_zero", 32'h8, 32'd0);
    wait_edges(2);
    expect_irq("os_irq_hold2", 1'b1);
    bus_write(32'h0, 32'h8);
    expect_irq("os_irq_ack", 1'b0);

    // Mode 1: pulses every 6 cycles with auto-reload, else one held IRQ.
    bus_write(32'h4, 32'd3);
    bus_write(32'h0, 32'hB);            // edge W
    for (int k = 1; k <= 20; k++) begin
      wait_edges(1);
      if (auto_en) e_irq = (k >= 5) && (((k - 5) % 6) == 0);
      else         e_irq = (k >= 5);
      expect_irq($sformatf("m1_irq_w%0d", k), e_irq);
    end
    bus_write(32'h0, 32'h8);
    wait_edges(3);
    expect_irq("m1_irq_off", 1'b0);
    expect_state("m1_idle", ST_IDLE);

    // PRESET=0 and PRESET=1 both interrupt at W+3.
    for (int p = 0; p <= 1; p++) begin
      bus_write(32'h4, p);
      bus_write(32'h0, 32'h9);          // edge W
      wait_edges(2);
      expect_rd($sformatf("p%0d_count_w2", p), 32'h8, p);
      expect_irq($sformatf("p%0d_irq_w2", p), 1'b0);
      wait_edges(1);
      expect_irq($sformatf("p%0d_irq_w3", p), 1'b1);
      expect_state($sformatf("p%0d_int", p), ST_INT);
      if (p == 1) begin
        // Bus write of EN=1 on the INT edge beats the FSM clearing EN.
        bus_write(32'h0, 32'h9);
        expect_rd("prio_ctrl", 32'h0, 32'h9);
        expect_irq("prio_irq_ack", 1'b0);
        wait_edges(1);
        expect_state("prio_reload", ST_LOAD);
      end
      bus_write(32'h0, 32'h8);
      wait_edges(3);
      expect_state($sformatf("p%0d_idle", p), ST_IDLE);
      expect_irq($sformatf("p%0d_irq_end", p), 1'b0);
    end

    // IM=0: no IRQ, FSM still reaches INT.
    bus_write(32'h4, 32'd10);
    bus_write(32'h0, 32'h1);            // edge W
    for (int k = 1; k <= 12; k++) begin
      wait_edges(1);
      expect_irq($sformatf("nm_irq_w%0d", k), 1'b0);
    end
    expect_state("nm_int", ST_INT);
    wait_edges(1);
    expect_rd("nm_ctrl", 32'h0, 32'h0);

    // Stop mid-count: CTRL=0 written while COUNT=4 freezes COUNT at 3.
    bus_write(32'h0, 32'h1);            // edge W2
    wait_edges(2);
    expect_rd("stop_count_w2", 32'h8, 32'd10);
    wait_edges(6);
    expect_rd("stop_count_4", 32'h8, 32'd4);
    bus_write(32'h0, 32'h0);
    expect_rd("stop_count_3", 32'h8, 32'd3);
    wait_edges(3);
    expect_rd("stop_count_held", 32'h8, 32'd3);
    expect_state("stop_idle", ST_IDLE);

    // Read-only COUNT, reserved slot, CTRL width, PRESET not applied until LOAD.
    bus_write(32'h8, 32'hFFFF_FFFF);
    expect_rd("count_ro", 32'h8, 32'd3);
    bus_write(32'hC, 32'h0000_FFFF);
    expect_rd("rsvd_ro", 32'hC, 32'd0);
    bus_write(32'h0, 32'hFFFF_FFF0);
    expect_rd("ctrl_width", 32'h0, 32'h0);
    bus_write(32'h4, 32'h0000_1234);
    expect_rd("preset_rw", 32'h4, 32'h0000_1234);
    expect_rd("preset_no_load", 32'h8, 32'd3);

    // Asynchronous reset while COUNT=7.
    bus_write(32'h4, 32'd20);
    bus_write(32'h0, 32'h9);            // edge W
    wait_edges(15);
    expect_rd("ar_count_7", 32'h8, 32'd7);
    reset = 1'b0;
    #1;
    expect_state("ar_state", ST_IDLE);
    expect_irq("ar_irq", 1'b0);
    expect_rd("ar_ctrl", 32'h0, 32'd0);
    expect_rd("ar_preset", 32'h4, PRESET_RST_VAL);
    expect_rd("ar_count", 32'h8, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      wait_edges(1);
      expect_irq($sformatf("ar_irq_after%0d", k), 1'b0);
    end
    expect_state("ar_stay_idle", ST_IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 SHALL have parameter PRESET_RST, default 32'd0, the reset value of the PRESET register.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port Addr, input, 32 bits: device address from the bridge; only Addr[3:2] is decoded.
REQ-005 SHALL have port WE, input, 1 bit: write enable, already qualified by the bridge hit.
REQ-006 SHALL have port Din, input, 32 bits: write data.
REQ-007 SHALL have port Dout, output, 32 bits: read data, combinational from Addr[3:2].
REQ-008 SHALL have port IRQ, output, 1 bit: interrupt request, registered.

Function
REQ-009 SHALL map registers as follows: offset 0x0 CTRL, 0x4 PRESET, 0x8 COUNT, 0xC reserved (reads 0, writes ignored).
REQ-010 CTRL SHALL store only bits [3:0]: [0] EN (enable), [2:1] MODE, [3] IM (interrupt mask); bits [31:4] read 0.
REQ-011 PRESET SHALL be read/write, 32 bits; a new value takes effect at the next LOAD only.
REQ-012 COUNT SHALL be read-only; writes to it are ignored.
REQ-013 SHALL implement FSM states IDLE, LOAD, CNT, INT.
REQ-014 In IDLE: if EN=1, go to LOAD; otherwise stay in IDLE.
REQ-015 In LOAD: COUNT<=PRESET; go to CNT.
REQ-016 In CNT: if EN=0, go to IDLE with COUNT held.
REQ-017 In CNT with EN=1: if COUNT>1, decrement COUNT; otherwise set COUNT<=0, set irq_flag, and go to INT.
REQ-018 In INT: go to IDLE; if MODE=0, also clear EN.
REQ-019 Timing: for PRESET=N>=1, with an EN write at edge W, the FSM SHALL be in LOAD after W+1, in CNT with COUNT=N after W+2, and in INT with irq_flag=1 after W+N+2; PRESET=0 SHALL behave as N=1.
REQ-020 Mode 0 (one-shot): irq_flag SHALL remain set until any write to CTRL.
REQ-021 Mode 1 (auto-reload): irq_flag SHALL clear on the INT->IDLE edge, giving exactly one cycle high; counting restarts automatically, for a period of N+3 cycles.
REQ-022 MODE values 2 and 3 SHALL behave as mode 0.
REQ-023 IRQ SHALL equal irq_flag AND IM.
REQ-024 A bus write to CTRL in the same cycle as an FSM update to EN SHALL win.
REQ-025 A write to CTRL with EN=0 while in CNT SHALL stop counting on the next edge.

Reset
REQ-026 On reset low, the block SHALL asynchronously set: state=IDLE, CTRL=0, COUNT=0, irq_flag=0, IRQ=0, PRESET=PRESET_RST.
REQ-027 Reset asserted mid-count SHALL abort the count with no IRQ; after release the block SHALL stay in IDLE until EN is written.

Configuration
REQ-028 With macro TC_AUTORELOAD_EN defined, mode 1 SHALL behave as in REQ-021.
REQ-029 Without TC_AUTORELOAD_EN, MODE[2:1] SHALL be stored but decoded as mode 0 in all cases.

Structure
REQ-030 Shared package tc_pkg SHALL hold the FSM state encoding, the register offsets (0x0/0x4/0x8), the CTRL bit indices and the MODE encodings.
REQ-031 No sub-module; the design SHALL be a single flat module.

Verification
REQ-032 Reset then read offsets 0x0/0x4/0x8/0xC -> 0, PRESET_RST, 0, 0.
REQ-033 PRESET=5, CTRL=0x9 at edge W -> COUNT=5 after W+2; IRQ rises after W+7 and holds; CTRL reads EN=0; a write of CTRL=0x8 drops IRQ on the next edge.
REQ-034 PRESET=3, CTRL=0xB (mode 1, IM=1) -> IRQ one-cycle pulses every 6 cycles; without TC_AUTORELOAD_EN -> a single held IRQ.
REQ-035 PRESET=0 or PRESET=1, CTRL=0x9 -> IRQ after W+3.
REQ-036 PRESET=10, CTRL=0x1 (IM=0) -> IRQ stays 0, FSM still reaches INT; a CTRL=0x0 write at COUNT=4 freezes COUNT at 3.
REQ-037 Pulse reset low while COUNT=7 -> all registers reset immediately and no IRQ ever appears.
